fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port between NREQ producers. Each producer presents a request plus data. The arbiter grants at most one producer per cycle and forwards the winning word to the FIFO through a registered write strobe and data. Occupancy is tracked with an internal credit counter, so grants never depend on the FIFO's lagging full flag.

## Interface
- NREQ, 4: number of producers, 2..8
- WIDTH, 16: data width
- DEPTH, 16: FIFO depth; initial credit count
- MAX_BURST, 4: consecutive accepts allowed per winner (burst build only)

Ports:
- clk  in  1  rising-edge clock
- rst_  in  1  asynchronous, active-low reset
- req  in  NREQ  per-producer request; producer holds req and its data until granted
- data  in  NREQ*WIDTH  producer i occupies bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  combinational one-hot grant; transfer occurs when req[i] & gnt[i] at a clock edge
- fifo_data_in  out  WIDTH  registered write data to the FIFO
- fifo_write  out  1  registered write strobe to the FIFO
- fifo_pop  in  1  one-cycle strobe for each word the consumer removes; returns one credit
- credits  out  $clog2(DEPTH)+1  free FIFO slots
- stall  out  1  high while in STALL
- credit_err  out  1  sticky; set when fifo_pop arrives with credits == DEPTH

## Operation
- Reset values: fifo_write 0, fifo_data_in 0, credits DEPTH, credit_err 0, stall 0. Round-robin pointer is 0, burst count is 0, FSM is IDLE. gnt is forced to 0 while rst_ is low.
- FSM states:
  - IDLE: no req. Goes to ACTIVE when any req and credits > 0. Goes to STALL when any req and credits == 0.
  - ACTIVE: grants every cycle. Goes to STALL when credits reach 0 while req is pending. Goes to IDLE when there is no req.
  - STALL: gnt = 0. Leaves on the first cycle credits > 0.
- Arbitration: gnt goes to the first requester at or after the pointer, in circular order NREQ-1 -> 0. Grant is given only when credits > 0.
- After an accept, the pointer moves to the winner index + 1, modulo NREQ.
- Credits:
  - accept only: decrement
  - fifo_pop only: increment
  - accept and fifo_pop in the same cycle: unchanged
  - never below 0 and never above DEPTH
- fifo_pop at credits == DEPTH is ignored and sets credit_err. credit_err is cleared only by reset.
- Reset mid-operation: the registered in-flight write is dropped (fifo_write returns to 0), and credits return to DEPTH.

## Timing
- Accept at edge t: fifo_write = 1 and fifo_data_in = winner's data during cycle t+1. Latency is one cycle.
- Throughput is one word per cycle while credits > 0. Back-to-back writes from different producers are allowed.
- gnt depends combinationally on req, the pointer and credits. There is no combinational path from data.
- When credits == 1 and an accept happens, gnt is 0 in the following cycle unless fifo_pop occurs in the same cycle as the accept.

## Configuration
- FIFO_ARB_BURST_EN defined:
  - The winner keeps priority for up to MAX_BURST consecutive accepts while its req stays high.
  - The pointer advances when the burst count reaches MAX_BURST or the winner's req drops. The burst count then resets to 0.
- FIFO_ARB_BURST_EN undefined: the pointer advances after every accept. The burst counter and MAX_BURST are not present.

## Structure
- Package fifo_arb_pkg holds:
  - state enum typedef (IDLE, ACTIVE, STALL)
  - default constants for NREQ, WIDTH, DEPTH, MAX_BURST
- Sub-module rr_arbiter: a combinational rotating-priority pick from a request vector and a pointer, returning a one-hot grant and the winner index. All registered state stays in fifo_wr_arbiter.

## Test plan
- Reset with req = 4'b1111 -> gnt = 0 during reset; after release, gnt = 0001, 0010, 0100, 1000, 0001 on consecutive cycles; fifo_write is high from the second cycle onward.
- DEPTH = 4, all req high, no fifo_pop -> exactly 4 accepts, then credits = 0, stall = 1, gnt = 0. One fifo_pop -> exactly one further accept.
- Accept and fifo_pop in the same cycle at credits = 2 -> credits stays 2.
- fifo_pop with credits = 16 -> credits stays 16, credit_err = 1 until reset.
- FIFO_ARB_BURST_EN, MAX_BURST = 4, req = 4'b0011 -> gnt = 0001 x4, then 0010 x4; without the macro, gnt alternates 0001 / 0010.
- rst_ driven low in the cycle after an accept -> fifo_write = 0 and credits = 16 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned DEPTH_DEF     = 16;
    localparam int unsigned MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first requester at or after ptr,
// wrapping from NREQ-1 back to 0. Returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    // Pass one searches [ptr, NREQ-1]; pass two only runs when that range is
    // empty, so its first hit is the lowest requester below ptr.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i] && (IDXW'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                idx    = IDXW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IDXW'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// Free FIFO slots are tracked with a local credit counter so grants never
// wait on the FIFO's lagging full flag.
// Optional feature: define FIFO_ARB_BURST_EN to let a winner keep priority
// for up to MAX_BURST consecutive accepts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned WIDTH     = WIDTH_DEF,
`ifdef FIFO_ARB_BURST_EN
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
`endif
    parameter int unsigned DEPTH     = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        fifo_data_in,
    output logic                    fifo_write,
    input  logic                    fifo_pop,
    output logic [$clog2(DEPTH):0]  credits,
    output logic                    stall,
    output logic                    credit_err
);

    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_nxt;
    logic [IDXW-1:0] win;
    logic [NREQ-1:0] pick;
    logic            pick_any;
    logic            any_req;
    logic            can_grant;
    logic            accept;
    logic            pop_full;
    logic            pop_ok;
    logic [CW-1:0]   credits_nxt;

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic [BW-1:0] run;
`endif

    // Circular successor of an index.
    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        return (i == IDXW'(NREQ - 1)) ? '0 : i + IDXW'(1);
    endfunction

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pick),
        .idx   (win),
        .found (pick_any)
    );

    // Grant only out of reset and with a free slot; no path from data.
    assign any_req   = |req;
    assign can_grant = rst_ && (credits != '0);
    assign gnt       = (can_grant && pick_any) ? pick : '0;
    assign accept    = |(req & gnt);
    assign pop_full  = fifo_pop && (credits == CRED_MAX);
    assign pop_ok    = fifo_pop && !pop_full;

    // Credit update; a pop with the FIFO already empty is discarded.
    always_comb begin
        credits_nxt = credits;
        case ({accept, pop_ok})
            2'b10:   credits_nxt = credits - CW'(1);
            2'b01:   credits_nxt = credits + CW'(1);
            default: credits_nxt = credits;
        endcase
    end

    // Priority pointer update, with optional burst hold on the winner.
    always_comb begin
        ptr_nxt = ptr;
`ifdef FIFO_ARB_BURST_EN
        burst_nxt = burst_cnt;
        run       = ((win == ptr) && (burst_cnt != '0)) ? burst_cnt + BW'(1) : BW'(1);
        if (accept) begin
            if (run == BW'(MAX_BURST)) begin
                ptr_nxt   = next_idx(win);
                burst_nxt = '0;
            end else begin
                ptr_nxt   = win;
                burst_nxt = run;
            end
        end else if ((burst_cnt != '0) && !req[ptr]) begin
            ptr_nxt   = next_idx(ptr);
            burst_nxt = '0;
        end
`else
        if (accept) begin
            ptr_nxt = next_idx(win);
        end
`endif
    end

    // Next state judged on post-edge credits so STALL always means zero credits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = (credits_nxt == '0) ? STALL : ACTIVE;
                end
            end
            ACTIVE: begin
                if (!any_req) begin
                    state_nxt = IDLE;
                end else if (credits_nxt == '0) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (credits_nxt != '0) begin
                    state_nxt = any_req ? ACTIVE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // All registered state: FSM, pointer, credits and the FIFO write port.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= IDLE;
            stall        <= 1'b0;
            ptr          <= '0;
            credits      <= CRED_MAX;
            credit_err   <= 1'b0;
            fifo_write   <= 1'b0;
            fifo_data_in <= '0;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            stall      <= (state_nxt == STALL);
            ptr        <= ptr_nxt;
            credits    <= credits_nxt;
            fifo_write <= accept;
            if (accept) begin
                fifo_data_in <= data[win*WIDTH +: WIDTH];
            end
            if (pop_full) begin
                credit_err <= 1'b1;
            end
`ifdef FIFO_ARB_BURST_EN
            burst_cnt <= burst_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by
// randomized traffic compared against a behavioural model of the arbiter.
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 16;
`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned MAX_BURST = 4;
`endif

    logic                  clk = 1'b0;
    logic                  rst_;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      fifo_data_in;
    logic                  fifo_write;
    logic                  fifo_pop;
    logic [4:0]            credits;
    logic                  stall;
    logic                  credit_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int               m_credits;
    int               m_ptr;
    int               m_owner;
    int               m_run;
    logic             m_write;
    logic [WIDTH-1:0] m_data;
    logic             m_err;
    logic             m_stall;
    logic [NREQ-1:0]  last_gnt;

    fifo_wr_arbiter dut (
        .clk          (clk),
        .rst_         (rst_),
        .req          (req),
        .data         (data),
        .gnt          (gnt),
        .fifo_data_in (fifo_data_in),
        .fifo_write   (fifo_write),
        .fifo_pop     (fifo_pop),
        .credits      (credits),
        .stall        (stall),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credits = int'(DEPTH);
        m_ptr     = 0;
        m_owner   = 0;
        m_run     = 0;
        m_write   = 1'b0;
        m_data    = '0;
        m_err     = 1'b0;
        m_stall   = 1'b0;
    endtask

    // First requester at or after the pointer, circularly; none without credit.
    function automatic logic [NREQ-1:0] model_gnt();
        logic [NREQ-1:0] g;
        int              i;
        g = '0;
        if (m_credits == 0) return g;
        for (int k = 0; k < int'(NREQ); k++) begin
            i = (m_ptr + k) % int'(NREQ);
            if (req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Apply one clock edge to the model given the grant seen in that cycle.
    task automatic model_edge(input logic [NREQ-1:0] g);
        int w;
        bit pop_ok;
        w = -1;
        for (int i = 0; i < int'(NREQ); i++) if (g[i]) w = i;
        pop_ok = fifo_pop && (m_credits != int'(DEPTH));
        if (fifo_pop && (m_credits == int'(DEPTH))) m_err = 1'b1;
        m_write = (w >= 0);
        if (w >= 0) m_data = data[w*WIDTH +: WIDTH];
`ifdef FIFO_ARB_BURST_EN
        if (w >= 0) begin
            m_run   = (w == m_owner && m_run > 0) ? m_run + 1 : 1;
            m_owner = w;
            if (m_run == int'(MAX_BURST)) begin
                m_ptr = (w + 1) % int'(NREQ);
                m_run = 0;
            end else begin
                m_ptr = w;
            end
        end else if (m_run > 0 && !req[m_ptr]) begin
            m_ptr = (m_ptr + 1) % int'(NREQ);
            m_run = 0;
        end
`else
        if (w >= 0) m_ptr = (w + 1) % int'(NREQ);
`endif
        m_credits = m_credits + (pop_ok ? 1 : 0) - ((w >= 0) ? 1 : 0);
        m_stall   = (m_credits == 0) && ((req != '0) || m_stall);
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic cycle(input logic [NREQ-1:0] r, input logic p);
        logic [NREQ-1:0] eg;
        req      = r;
        fifo_pop = p;
        for (int i = 0; i < int'(NREQ); i++) data[i*WIDTH +: WIDTH] = 16'($urandom);
        #1;
        eg       = model_gnt();
        last_gnt = gnt;
        chk("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        model_edge(eg);
        @(negedge clk);
        chk("fifo_write", 32'(fifo_write), 32'(m_write));
        chk("fifo_data_in", 32'(fifo_data_in), 32'(m_data));
        chk("credits", 32'(credits), 32'(m_credits));
        chk("credit_err", 32'(credit_err), 32'(m_err));
        chk("stall", 32'(stall), 32'(m_stall));
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_fifo_write", 32'(fifo_write), 32'd0);
        chk("rst_fifo_data_in", 32'(fifo_data_in), 32'd0);
        chk("rst_credits", 32'(credits), 32'(DEPTH));
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [NREQ-1:0] seq_exp [0:4];
        logic [NREQ-1:0] alt_exp [0:7];
        int              n_acc;

        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;
`ifdef FIFO_ARB_BURST_EN
        for (int i = 0; i < 8; i++) alt_exp[i] = (i < 4) ? 4'b0001 : 4'b0010;
`else
        for (int i = 0; i < 8; i++) alt_exp[i] = (i % 2 == 0) ? 4'b0001 : 4'b0010;
`endif

        rst_     = 1'b1;
        req      = 4'b1111;
        data     = '0;
        fifo_pop = 1'b0;
        model_reset();
        #2;

        // Reset with all requests high, then round-robin rotation and drain to stall
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(4'b1111, 1'b0);
            if (c < 5) chk($sformatf("rr_seq%0d", c), 32'(last_gnt), 32'(seq_exp[c]));
            if (c == 0) chk("write_second_cycle", 32'(fifo_write), 32'd1);
            if (last_gnt != '0) n_acc++;
        end
        chk("accepts_to_empty", 32'(n_acc), 32'(DEPTH));
        chk("stall_at_zero", 32'(stall), 32'd1);
        chk("gnt_at_zero", 32'(last_gnt), 32'd0);
        chk("credits_zero", 32'(credits), 32'd0);

        // One returned credit allows exactly one more accept
        cycle(4'b1111, 1'b1);
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(4'b1111, 1'b0);
            if (last_gnt != '0) n_acc++;
        end
        chk("accepts_after_pop", 32'(n_acc), 32'd1);

        // Accept and pop together at credits == 2
        do_reset();
        for (int c = 0; c < 14; c++) cycle(4'b0001, 1'b0);
        chk("credits_two", 32'(credits), 32'd2);
        cycle(4'b0001, 1'b1);
        chk("accept_pop_same", 32'(credits), 32'd2);

        // Pop with no words outstanding: ignored and sticky error
        do_reset();
        cycle(4'b0000, 1'b1);
        chk("overpop_credits", 32'(credits), 32'(DEPTH));
        chk("overpop_err", 32'(credit_err), 32'd1);
        for (int c = 0; c < 3; c++) cycle(4'b0000, 1'b0);
        chk("overpop_err_sticky", 32'(credit_err), 32'd1);

        // Two producers contending
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(4'b0011, 1'b0);
            chk($sformatf("pair_gnt%0d", c), 32'(last_gnt), 32'(alt_exp[c]));
        end

        // Asynchronous reset one cycle after an accept
        req      = 4'b0001;
        fifo_pop = 1'b0;
        @(posedge clk);
        #2;
        chk("write_before_rst", 32'(fifo_write), 32'd1);
        rst_ = 1'b0;
        #1;
        chk("async_rst_write", 32'(fifo_write), 32'd0);
        chk("async_rst_credits", 32'(credits), 32'(DEPTH));
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        model_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
